median5_sorter: RTL and testbench



---
 rtl/median5_sorter_pkg.sv | 19 +
 rtl/median5_sorter_if.sv | 37 +++
 rtl/median5_sorter_ch.sv | 58 +++++
 rtl/median5_sorter.sv | 70 +++++++
 tb/tb_median5_sorter.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/median5_sorter_pkg.sv
// rtl/median5_sorter_pkg.sv - shared widths, latency, pixel/channel types and min/max helpers
package median_pkg;

    localparam int DATA_W_DEF = 24;
    localparam int CH_W_DEF   = 8;
    localparam int MED5_LAT   = 5;

    typedef logic [DATA_W_DEF-1:0] pixel_t;
    typedef logic [CH_W_DEF-1:0]   channel_t;

    function automatic channel_t ch_min(input channel_t a, input channel_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic channel_t ch_max(input channel_t a, input channel_t b);
        return (a < b) ? b : a;
    endfunction

endpackage

// File: rtl/median5_sorter_if.sv
// rtl/median5_sorter_if.sv - window-in / median-out bundle; MEDIAN5_BYPASS_EN adds the bypass flag
interface median5_sorter_if #(
    parameter int DATA_W = 24
);
    logic              in_valid;
    logic              in_sof;
    logic              in_eol;
    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic [DATA_W-1:0] d3;
    logic [DATA_W-1:0] d4;
`ifdef MEDIAN5_BYPASS_EN
    logic              bypass;
`endif
    logic              out_valid;
    logic              out_sof;
    logic              out_eol;
    logic [DATA_W-1:0] dout;

    modport master (
        output in_valid, in_sof, in_eol, d0, d1, d2, d3, d4,
`ifdef MEDIAN5_BYPASS_EN
        output bypass,
`endif
        input  out_valid, out_sof, out_eol, dout
    );

    modport slave (
        input  in_valid, in_sof, in_eol, d0, d1, d2, d3, d4,
`ifdef MEDIAN5_BYPASS_EN
        input  bypass,
`endif
        output out_valid, out_sof, out_eol, dout
    );

endinterface

// File: rtl/median5_sorter_ch.sv
// rtl/median5_sorter_ch.sv - one channel's 5-stage compare-exchange median network, data only
module median5_ch
    import median_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  channel_t d0,
    input  channel_t d1,
    input  channel_t d2,
    input  channel_t d3,
    input  channel_t d4,
    output channel_t dout
);

    channel_t s1_a, s1_b, s1_c, s1_d, s1_e;
    channel_t s2_x, s2_y, s2_c;
    channel_t s3_lo, s3_hi, s3_y;
    channel_t s4_t, s4_lo;
    channel_t s5_m;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_a  <= '0;
            s1_b  <= '0;
            s1_c  <= '0;
            s1_d  <= '0;
            s1_e  <= '0;
            s2_x  <= '0;
            s2_y  <= '0;
            s2_c  <= '0;
            s3_lo <= '0;
            s3_hi <= '0;
            s3_y  <= '0;
            s4_t  <= '0;
            s4_lo <= '0;
            s5_m  <= '0;
        end else begin
            s1_a  <= ch_min(d0, d1);
            s1_b  <= ch_max(d0, d1);
            s1_c  <= d2;
            s1_d  <= ch_min(d3, d4);
            s1_e  <= ch_max(d3, d4);
            // larger of the two pair-minima and smaller of the two pair-maxima drop the extremes
            s2_x  <= ch_max(s1_a, s1_d);
            s2_y  <= ch_min(s1_b, s1_e);
            s2_c  <= s1_c;
            s3_lo <= ch_min(s2_x, s2_c);
            s3_hi <= ch_max(s2_x, s2_c);
            s3_y  <= s2_y;
            s4_t  <= ch_min(s3_hi, s3_y);
            s4_lo <= s3_lo;
            s5_m  <= ch_max(s4_lo, s4_t);
        end
    end

    assign dout = s5_m;

endmodule

// File: rtl/median5_sorter.sv
// rtl/median5_sorter.sv - per-channel median of a 5-pixel window, 5-cycle latency; MEDIAN5_BYPASS_EN passes d2 per pixel
module median5_sorter
    import median_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CH_W   = CH_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    median5_sorter_if.slave bus
);

    localparam int N_CH = DATA_W / CH_W;

    logic [DATA_W-1:0]   med;
    logic [MED5_LAT-1:0] vld_sr;
    logic [MED5_LAT-1:0] sof_sr;
    logic [MED5_LAT-1:0] eol_sr;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        median5_ch u_ch (
            .clk  (clk),
            .rst  (rst),
            .d0   (bus.d0[k*CH_W +: CH_W]),
            .d1   (bus.d1[k*CH_W +: CH_W]),
            .d2   (bus.d2[k*CH_W +: CH_W]),
            .d3   (bus.d3[k*CH_W +: CH_W]),
            .d4   (bus.d4[k*CH_W +: CH_W]),
            .dout (med[k*CH_W +: CH_W])
        );
    end

    // sideband is masked on entry so it can never appear without valid
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr <= '0;
            sof_sr <= '0;
            eol_sr <= '0;
        end else begin
            vld_sr <= {vld_sr[MED5_LAT-2:0], bus.in_valid};
            sof_sr <= {sof_sr[MED5_LAT-2:0], bus.in_valid & bus.in_sof};
            eol_sr <= {eol_sr[MED5_LAT-2:0], bus.in_valid & bus.in_eol};
        end
    end

    assign bus.out_valid = vld_sr[MED5_LAT-1];
    assign bus.out_sof   = sof_sr[MED5_LAT-1];
    assign bus.out_eol   = eol_sr[MED5_LAT-1];

`ifdef MEDIAN5_BYPASS_EN
    logic [MED5_LAT-1:0] byp_sr;
    logic [DATA_W-1:0]   ctr_sr [MED5_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            byp_sr <= '0;
            for (int i = 0; i < MED5_LAT; i++) ctr_sr[i] <= '0;
        end else begin
            byp_sr    <= {byp_sr[MED5_LAT-2:0], bus.bypass};
            ctr_sr[0] <= bus.d2;
            for (int i = 1; i < MED5_LAT; i++) ctr_sr[i] <= ctr_sr[i-1];
        end
    end

    assign bus.dout = byp_sr[MED5_LAT-1] ? ctr_sr[MED5_LAT-1] : med;
`else
    assign bus.dout = med;
`endif

endmodule

// File: tb/tb_median5_sorter.sv
// tb/tb_median5_sorter.sv - randomized bench against a sort-based median model; MEDIAN5_BYPASS_EN covers bypass
module tb_median5_sorter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    median5_sorter_if #(.DATA_W(24)) bus ();

    median5_sorter u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        v;
        logic        s;
        logic        e;
        logic [23:0] px;
        bit          chk;
    } ent_t;

    ent_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] med5(input logic [23:0] a, b, c, d, e);
        logic [23:0] r;
        int v[5];
        int t;
        for (int k = 0; k < 3; k++) begin
            v[0] = int'(a[k*8 +: 8]); v[1] = int'(b[k*8 +: 8]); v[2] = int'(c[k*8 +: 8]);
            v[3] = int'(d[k*8 +: 8]); v[4] = int'(e[k*8 +: 8]);
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 4 - i; j++)
                    if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
            r[k*8 +: 8] = v[2][7:0];
        end
        return r;
    endfunction

    function automatic logic [23:0] ref_out();
        logic [23:0] m;
        m = med5(bus.d0, bus.d1, bus.d2, bus.d3, bus.d4);
`ifdef MEDIAN5_BYPASS_EN
        if (bus.bypass) m = bus.d2;
`endif
        return m;
    endfunction

    // one clock: model consumes the inputs seen at the edge, then outputs are checked 1ns later
    task automatic step();
        ent_t e;
        ent_t x;
        @(posedge clk);
        if (rst) begin
            q.delete();
            e = '{v: 1'b0, s: 1'b0, e: 1'b0, px: 24'h0, chk: 1'b0};
            for (int i = 0; i < 4; i++) q.push_back(e);
            x = '{v: 1'b0, s: 1'b0, e: 1'b0, px: 24'h0, chk: 1'b1};
        end else begin
            e.v   = bus.in_valid;
            e.s   = bus.in_valid & bus.in_sof;
            e.e   = bus.in_valid & bus.in_eol;
            e.px  = ref_out();
            e.chk = bus.in_valid;
            q.push_back(e);
            x = q.pop_front();
        end
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(x.v));
        chk("out_sof", 32'(bus.out_sof), 32'(x.s));
        chk("out_eol", 32'(bus.out_eol), 32'(x.e));
        if (x.chk) chk("dout", 32'(bus.dout), 32'(x.px));
        @(negedge clk);
    endtask

    task automatic set_win(input logic [23:0] a, b, c, d, e);
        bus.d0 = a; bus.d1 = b; bus.d2 = c; bus.d3 = d; bus.d4 = e;
    endtask

    task automatic rand_win();
        set_win(24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom));
    endtask

    task automatic one_window(input logic [23:0] a, b, c, d, e, input logic [23:0] expv, input string tag);
        set_win(a, b, c, d, e);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        rand_win();
        repeat (4) step();
        chk(tag, 32'(bus.dout), 32'(expv));
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    endtask

    initial begin
        logic [3:0]  pat;
        logic [23:0] w[5];
        int          win;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_eol   = 1'b0;
`ifdef MEDIAN5_BYPASS_EN
        bus.bypass   = 1'b0;
`endif
        set_win(24'h0, 24'h0, 24'h0, 24'h0, 24'h0);
        @(negedge clk);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();

        one_window({3{8'd10}}, {3{8'd50}}, {3{8'd30}}, {3{8'd20}}, {3{8'd40}}, 24'h1E1E1E, "all_ch");
        one_window({8'd1, 8'd5, 8'd9}, {8'd2, 8'd4, 8'd9}, {8'd3, 8'd3, 8'd0},
                   {8'd4, 8'd2, 8'd0}, {8'd5, 8'd1, 8'd9}, {8'd3, 8'd3, 8'd9}, "indep_ch");
        one_window({3{8'hFF}}, {3{8'h00}}, {3{8'hFF}}, {3{8'h00}}, {3{8'h80}}, 24'h808080, "extremes");
        one_window({3{8'h55}}, {3{8'h55}}, {3{8'h55}}, {3{8'h55}}, {3{8'h55}}, 24'h555555, "all_equal");

        // 20 windows with valid pattern 1,1,0,1; stray sof/eol on gap cycles must be masked
        pat = 4'b1101;
        win = 0;
        for (int i = 0; win < 20; i++) begin
            bus.in_valid = pat[3 - (i % 4)];
            rand_win();
            if (bus.in_valid) begin
                bus.in_sof = (win == 0);
                bus.in_eol = (win == 19);
                win++;
            end else begin
                bus.in_sof = 1'($urandom);
                bus.in_eol = 1'($urandom);
            end
            step();
        end
        bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_eol = 1'b0;
        repeat (6) step();

        // reset with 3 windows in flight; in_valid during reset is ignored
        repeat (3) begin
            bus.in_valid = 1'b1;
            rand_win();
            step();
        end
        rst = 1'b1;
        step();
        chk("rst_dout", 32'(bus.dout), 32'd0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        repeat (2) step();
        for (int i = 0; i < 5; i++) w[i] = 24'($urandom);
        one_window(w[0], w[1], w[2], w[3], w[4], med5(w[0], w[1], w[2], w[3], w[4]), "post_rst");

`ifdef MEDIAN5_BYPASS_EN
        set_win({3{8'd10}}, {3{8'd50}}, {3{8'd30}}, {3{8'd20}}, {3{8'd40}});
        bus.in_valid = 1'b1; bus.bypass = 1'b0;
        step();
        set_win({3{8'd1}}, {3{8'd2}}, {3{8'd99}}, {3{8'd3}}, {3{8'd4}});
        bus.bypass = 1'b1;
        step();
        bus.in_valid = 1'b0; bus.bypass = 1'b0;
        rand_win();
        repeat (3) step();
        chk("byp_med", 32'(bus.dout), 32'h1E1E1E);
        step();
        chk("byp_d2", 32'(bus.dout), 32'h636363);
        chk("byp_d2_valid", 32'(bus.out_valid), 32'd1);
`endif

        for (int i = 0; i < 200; i++) begin
            bus.in_valid = 1'($urandom);
            bus.in_sof   = 1'($urandom);
            bus.in_eol   = 1'($urandom);
`ifdef MEDIAN5_BYPASS_EN
            bus.bypass   = 1'($urandom);
`endif
            rand_win();
            step();
        end
        bus.in_valid = 1'b0;
        repeat (6) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
